pipeline_hazard_ctrl: RTL and testbench

//  Hazard and sequencing controller for the 5-stage CPU pipeline (IF/ID/EX/MEM/WB).
//  - Sources: decode-stage register indices plus EX/MEM stage control bits.
//  - Drives stall and flush enables to the pipeline registers, and operand-forwarding

---
 rtl/pipeline_hazard_ctrl_if.sv | 41 ++++
 rtl/pipeline_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline <-> hazard controller signal bundle
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 4
);
    logic [REG_W-1:0] id_r2;
    logic [REG_W-1:0] id_r3;
    logic [REG_W-1:0] ex_dest;
    logic             ex_wreg;
    logic             ex_rmem;
    logic             br_taken_e;
    logic [REG_W-1:0] mem_dest;
    logic             mem_wreg;
    logic             mem_req_m;
    logic             mem_ack;

    logic             stall_f;
    logic             stall_d;
    logic             stall_e;
    logic             stall_m;
    logic             flush_d;
    logic             flush_e;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             busy;
    logic             timeout_err;

    // Pipeline side: supplies stage status, consumes stall/flush/forward controls.
    modport master (
        output id_r2, id_r3, ex_dest, ex_wreg, ex_rmem, br_taken_e,
               mem_dest, mem_wreg, mem_req_m, mem_ack,
        input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
               fwd_a, fwd_b, busy, timeout_err
    );

    modport slave (
        input  id_r2, id_r3, ex_dest, ex_wreg, ex_rmem, br_taken_e,
               mem_dest, mem_wreg, mem_req_m, mem_ack,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
               fwd_a, fwd_b, busy, timeout_err
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline hazard, forwarding and stall/flush sequencer
module pipeline_hazard_ctrl #(
    parameter int REG_W        = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  hz
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FLUSH    = 2'b10
    } state_t;

    localparam logic [2:0] FL_INIT    = 3'(FLUSH_CYCLES);
    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic [2:0] fl_cnt, fl_cnt_nxt;
    logic       timeout_err, timeout_nxt;

    logic [REG_W-1:0] r2, r3, ex_dest, mem_dest;
    logic             mem_block;
    logic             load_use;
    logic             stall_all;
    logic             stall_fd;
    logic             flush_d_c;
    logic             flush_e_c;
    logic [1:0]       fwd_a_c, fwd_b_c;

    assign r2       = hz.id_r2;
    assign r3       = hz.id_r3;
    assign ex_dest  = hz.ex_dest;
    assign mem_dest = hz.mem_dest;

    assign mem_block = hz.mem_req_m & ~hz.mem_ack;
    assign load_use  = hz.ex_rmem & hz.ex_wreg & ((ex_dest == r2) | (ex_dest == r3));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= 8'd0;
            fl_cnt      <= 3'd0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            fl_cnt      <= fl_cnt_nxt;
            timeout_err <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        fl_cnt_nxt   = fl_cnt;
        timeout_nxt  = timeout_err;
        stall_all    = 1'b0;
        stall_fd     = 1'b0;
        flush_d_c    = 1'b0;
        flush_e_c    = 1'b0;

        case (state)
            RUN: begin
                if (mem_block) begin
                    stall_all    = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 8'd1;
                end else if (hz.br_taken_e) begin
                    flush_d_c = 1'b1;
                    flush_e_c = 1'b1;
                    if (FLUSH_CYCLES > 0) begin
                        state_nxt  = FLUSH;
                        fl_cnt_nxt = FL_INIT;
                    end
                end else if (load_use) begin
                    // One bubble: hold IF/ID and fetch, squash what enters EX.
                    stall_fd  = 1'b1;
                    flush_e_c = 1'b1;
                end
            end

            MEM_WAIT: begin
                // A redirect in EX is held with the stage and acted on after release.
                if (hz.mem_ack) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = 8'd0;
                end else if (wait_cnt == TIMEOUT_LIM) begin
                    timeout_nxt  = 1'b1;
                    state_nxt    = RUN;
                    wait_cnt_nxt = 8'd0;
                end else begin
                    stall_all    = 1'b1;
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end

            FLUSH: begin
                flush_d_c = 1'b1;
                if (mem_block) begin
                    stall_all = 1'b1;
                end else begin
                    fl_cnt_nxt = fl_cnt - 3'd1;
                    if (fl_cnt <= 3'd1) begin
                        state_nxt  = RUN;
                        fl_cnt_nxt = 3'd0;
                    end
                end
            end

            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = 8'd0;
                fl_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // EX result wins over MEM; a load in EX has no result yet so it cannot forward.
    always_comb begin
        fwd_a_c = 2'b00;
        fwd_b_c = 2'b00;
        if (hz.ex_wreg & ~hz.ex_rmem & (ex_dest == r2))
            fwd_a_c = 2'b01;
        else if (hz.mem_wreg & (mem_dest == r2))
            fwd_a_c = 2'b10;
        if (hz.ex_wreg & ~hz.ex_rmem & (ex_dest == r3))
            fwd_b_c = 2'b01;
        else if (hz.mem_wreg & (mem_dest == r3))
            fwd_b_c = 2'b10;
    end

    assign hz.stall_f     = ~rst & (stall_all | stall_fd);
    assign hz.stall_d     = ~rst & (stall_all | stall_fd);
    assign hz.stall_e     = ~rst & stall_all;
    assign hz.stall_m     = ~rst & stall_all;
    assign hz.flush_d     = ~rst & flush_d_c;
    assign hz.flush_e     = ~rst & flush_e_c;
    assign hz.fwd_a       = rst ? 2'b00 : fwd_a_c;
    assign hz.fwd_b       = rst ? 2'b00 : fwd_b_c;
    assign hz.busy        = ~rst & (state != RUN);
    assign hz.timeout_err = timeout_err;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_W(4)) hz ();

    pipeline_hazard_ctrl #(
        .REG_W(4),
        .FLUSH_CYCLES(2),
        .MEM_TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz(hz.slave)
    );

    // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, busy}
    wire [6:0] ctl = {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m,
                      hz.flush_d, hz.flush_e, hz.busy};

    localparam logic [6:0] C_IDLE     = 7'b0000000;
    localparam logic [6:0] C_LU       = 7'b1100010;
    localparam logic [6:0] C_MS_RUN   = 7'b1111000;
    localparam logic [6:0] C_MS_WAIT  = 7'b1111001;
    localparam logic [6:0] C_REL_WAIT = 7'b0000001;
    localparam logic [6:0] C_BR       = 7'b0000110;
    localparam logic [6:0] C_FL       = 7'b0000101;
    localparam logic [6:0] C_FL_STALL = 7'b1111101;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.id_r2 = 4'd0; hz.id_r3 = 4'd0; hz.ex_dest = 4'd0; hz.ex_wreg = 1'b0;
        hz.ex_rmem = 1'b0; hz.br_taken_e = 1'b0; hz.mem_dest = 4'd0;
        hz.mem_wreg = 1'b0; hz.mem_req_m = 1'b0; hz.mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        hz.ex_wreg = 1'b1; hz.ex_dest = 4'd2; hz.id_r2 = 4'd2;
        hz.mem_req_m = 1'b1; hz.br_taken_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            n_checks++;
            if (ctl !== 7'b0000000) begin n_fail++; $display("FAIL reset_ctl[%0d]: got %b want %b", i, ctl, 7'b0000000); end
            n_checks++;
            if (hz.fwd_a !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_a[%0d]: got %b want 00", i, hz.fwd_a); end
            tick();
        end
        n_checks++;
        if (hz.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b want 0", hz.timeout_err); end
        rst = 1'b0;
        idle();
        hz.mem_req_m = 1'b1;
        #3;
        n_checks++;
        if (ctl !== C_MS_RUN) begin n_fail++; $display("FAIL reset_ms_run: got %b want %b", ctl, C_MS_RUN); end
        tick();
        #3;
        n_checks++;
        if (ctl !== C_MS_WAIT) begin n_fail++; $display("FAIL reset_ms_wait: got %b want %b", ctl, C_MS_WAIT); end
        rst = 1'b1;
        #0.5;
        n_checks++;
        if (ctl !== 7'b0000000) begin n_fail++; $display("FAIL reset_in_wait_ctl: got %b want %b", ctl, 7'b0000000); end
        tick();
        rst = 1'b0;
        idle();
        #3;
        n_checks++;
        if (ctl !== C_IDLE) begin n_fail++; $display("FAIL reset_from_wait_run: got %b want %b", ctl, C_IDLE); end
        tick();
    endtask

    task automatic test_load_use();
        idle();
        hz.ex_rmem = 1'b1; hz.ex_wreg = 1'b1; hz.ex_dest = 4'd5; hz.id_r3 = 4'd5; hz.id_r2 = 4'd0;
        #3;
        n_checks++;
        if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_r3_ctl: got %b want %b", ctl, C_LU); end
        n_checks++;
        if (hz.fwd_b !== 2'b00) begin n_fail++; $display("FAIL lu_fwd_b: got %b want 00", hz.fwd_b); end
        tick();
        idle();
        #3;
        n_checks++;
        if (ctl !== C_IDLE) begin n_fail++; $display("FAIL lu_one_bubble: got %b want %b", ctl, C_IDLE); end
        tick();
        hz.ex_rmem = 1'b1; hz.ex_wreg = 1'b1; hz.ex_dest = 4'd9; hz.id_r2 = 4'd9; hz.id_r3 = 4'd1;
        #3;
        n_checks++;
        if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_r2_ctl: got %b want %b", ctl, C_LU); end
        tick();
        hz.ex_wreg = 1'b0;
        #3;
        n_checks++;
        if (ctl !== C_IDLE) begin n_fail++; $display("FAIL lu_no_wreg: got %b want %b", ctl, C_IDLE); end
        tick();
        idle();
    endtask

    task automatic test_forwarding();
        idle();
        hz.ex_wreg = 1'b1; hz.ex_dest = 4'd3; hz.mem_wreg = 1'b1; hz.mem_dest = 4'd3;
        hz.id_r2 = 4'd3; hz.id_r3 = 4'd7;
        #3;
        n_checks++;
        if (hz.fwd_a !== 2'b01) begin n_fail++; $display("FAIL fwd_a_ex_prio: got %b want 01", hz.fwd_a); end
        n_checks++;
        if (hz.fwd_b !== 2'b00) begin n_fail++; $display("FAIL fwd_b_none: got %b want 00", hz.fwd_b); end
        n_checks++;
        if (ctl !== C_IDLE) begin n_fail++; $display("FAIL fwd_no_stall: got %b want %b", ctl, C_IDLE); end
        tick();
        hz.ex_wreg = 1'b0; hz.id_r3 = 4'd3;
        #3;
        n_checks++;
        if (hz.fwd_a !== 2'b10) begin n_fail++; $display("FAIL fwd_a_mem: got %b want 10", hz.fwd_a); end
        n_checks++;
        if (hz.fwd_b !== 2'b10) begin n_fail++; $display("FAIL fwd_b_mem: got %b want 10", hz.fwd_b); end
        tick();
        hz.ex_wreg = 1'b1; hz.ex_rmem = 1'b1; hz.ex_dest = 4'd3;
        #3;
        n_checks++;
        if (hz.fwd_a !== 2'b10) begin n_fail++; $display("FAIL fwd_a_load_blocks_ex: got %b want 10", hz.fwd_a); end
        n_checks++;
        if (ctl !== C_LU) begin n_fail++; $display("FAIL fwd_load_use_ctl: got %b want %b", ctl, C_LU); end
        tick();
        idle();
        hz.ex_wreg = 1'b1; hz.ex_dest = 4'd12; hz.id_r3 = 4'd12; hz.id_r2 = 4'd4;
        #3;
        n_checks++;
        if (hz.fwd_b !== 2'b01) begin n_fail++; $display("FAIL fwd_b_ex: got %b want 01", hz.fwd_b); end
        n_checks++;
        if (hz.fwd_a !== 2'b00) begin n_fail++; $display("FAIL fwd_a_regfile: got %b want 00", hz.fwd_a); end
        tick();
        idle();
    endtask

    task automatic test_mem_wait();
        idle();
        hz.mem_req_m = 1'b1; hz.mem_ack = 1'b1;
        #3;
        n_checks++;
        if (ctl !== C_IDLE) begin n_fail++; $display("FAIL mem_single_cycle: got %b want %b", ctl, C_IDLE); end
        tick();
        hz.mem_ack = 1'b0;
        #3;
        n_checks++;
        if (ctl !== C_MS_RUN) begin n_fail++; $display("FAIL mem_wait_c1: got %b want %b", ctl, C_MS_RUN); end
        tick();
        hz.br_taken_e = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            #3;
            n_checks++;
            if (ctl !== C_MS_WAIT) begin n_fail++; $display("FAIL mem_wait_c%0d: got %b want %b", i, ctl, C_MS_WAIT); end
            tick();
        end
        hz.br_taken_e = 1'b0; hz.mem_ack = 1'b1;
        #3;
        n_checks++;
        if (ctl !== C_REL_WAIT) begin n_fail++; $display("FAIL mem_ack_release: got %b want %b", ctl, C_REL_WAIT); end
        tick();
        idle();
        #3;
        n_checks++;
        if (ctl !== C_IDLE) begin n_fail++; $display("FAIL mem_back_to_run: got %b want %b", ctl, C_IDLE); end
        n_checks++;
        if (hz.timeout_err !== 1'b0) begin n_fail++; $display("FAIL mem_no_timeout: got %b want 0", hz.timeout_err); end
        tick();
    endtask

    task automatic test_redirect();
        idle();
        hz.br_taken_e = 1'b1;
        #3;
        n_checks++;
        if (ctl !== C_BR) begin n_fail++; $display("FAIL br_c0: got %b want %b", ctl, C_BR); end
        tick();
        hz.ex_rmem = 1'b1; hz.ex_wreg = 1'b1; hz.ex_dest = 4'd6; hz.id_r2 = 4'd6;
        #3;
        n_checks++;
        if (ctl !== C_FL) begin n_fail++; $display("FAIL br_c1_ignores: got %b want %b", ctl, C_FL); end
        tick();
        idle();
        #3;
        n_checks++;
        if (ctl !== C_FL) begin n_fail++; $display("FAIL br_c2: got %b want %b", ctl, C_FL); end
        tick();
        #3;
        n_checks++;
        if (ctl !== C_IDLE) begin n_fail++; $display("FAIL br_done: got %b want %b", ctl, C_IDLE); end
        tick();
        hz.br_taken_e = 1'b1;
        #3;
        n_checks++;
        if (ctl !== C_BR) begin n_fail++; $display("FAIL brs_c0: got %b want %b", ctl, C_BR); end
        tick();
        hz.br_taken_e = 1'b0;
        #3;
        n_checks++;
        if (ctl !== C_FL) begin n_fail++; $display("FAIL brs_c1: got %b want %b", ctl, C_FL); end
        tick();
        hz.mem_req_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            n_checks++;
            if (ctl !== C_FL_STALL) begin n_fail++; $display("FAIL brs_stall[%0d]: got %b want %b", i, ctl, C_FL_STALL); end
            tick();
        end
        hz.mem_req_m = 1'b0;
        #3;
        n_checks++;
        if (ctl !== C_FL) begin n_fail++; $display("FAIL brs_c2_resume: got %b want %b", ctl, C_FL); end
        tick();
        #3;
        n_checks++;
        if (ctl !== C_IDLE) begin n_fail++; $display("FAIL brs_done: got %b want %b", ctl, C_IDLE); end
        tick();
    endtask

    task automatic test_timeout();
        idle();
        hz.mem_req_m = 1'b1;
        #3;
        n_checks++;
        if (ctl !== C_MS_RUN) begin n_fail++; $display("FAIL to_c1: got %b want %b", ctl, C_MS_RUN); end
        tick();
        for (int i = 2; i <= 15; i++) begin
            #3;
            n_checks++;
            if (ctl !== C_MS_WAIT) begin n_fail++; $display("FAIL to_c%0d: got %b want %b", i, ctl, C_MS_WAIT); end
            tick();
        end
        #3;
        n_checks++;
        if (ctl !== C_REL_WAIT) begin n_fail++; $display("FAIL to_release: got %b want %b", ctl, C_REL_WAIT); end
        n_checks++;
        if (hz.timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_err_early: got %b want 0", hz.timeout_err); end
        tick();
        idle();
        #3;
        n_checks++;
        if (ctl !== C_IDLE) begin n_fail++; $display("FAIL to_back_to_run: got %b want %b", ctl, C_IDLE); end
        n_checks++;
        if (hz.timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err_set: got %b want 1", hz.timeout_err); end
        tick();
        hz.mem_req_m = 1'b1;
        tick();
        hz.mem_ack = 1'b1;
        tick();
        idle();
        tick();
        #3;
        n_checks++;
        if (hz.timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b want 1", hz.timeout_err); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #3;
        n_checks++;
        if (hz.timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_err_cleared: got %b want 0", hz.timeout_err); end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        test_reset();
        test_load_use();
        test_forwarding();
        test_mem_wait();
        test_redirect();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
